// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32 data memory behind valid/ready request and response channels.
// One access in flight; faulting accesses complete with a coded fault response.
module dmem_ctrl #(
  parameter int DEPTH_BYTES  = 1024,
  parameter int RD_LAT       = 1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  rsp_fault_code
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int IW    = (AW > 2) ? AW - 2 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_ALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE = 2'd2;
  localparam logic [1:0] FC_F3    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] mem_q [WORDS];

  logic        accept;
  logic [1:0]  sz;
  logic [1:0]  off;
  logic [IW-1:0] idx;
  logic        illegal, misal, oor;
  logic [32:0] size33, last33;
  logic [1:0]  code;
  logic [31:0] word, shifted, load_val;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        wr_en;

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_fault      = fault_q;
  assign rsp_fault_code = code_q;

  assign accept = req_valid && (state_q == S_IDLE);
  assign sz     = req_funct3[1:0];
  assign off    = req_addr[1:0];
  assign idx    = req_addr[IW+1:2];

  // Fault classification; the range test runs in 33 bits so top-of-space addresses cannot wrap.
  always_comb begin
    if (req_we) illegal = req_funct3[2] || (sz == 2'b11);
    else        illegal = (sz == 2'b11) || (req_funct3 == 3'b110);
    misal  = ((sz == 2'b01) && req_addr[0]) || ((sz == 2'b10) && (off != 2'b00));
    case (sz)
      2'b00:   size33 = 33'd1;
      2'b01:   size33 = 33'd2;
      default: size33 = 33'd4;
    endcase
    last33 = {1'b0, req_addr} + size33 - 33'd1;
    oor    = (last33 >= 33'(DEPTH_BYTES));
    if (illegal)    code = FC_F3;
    else if (misal) code = FC_ALIGN;
    else if (oor)   code = FC_RANGE;
    else            code = FC_NONE;
  end

  always_comb begin
    word    = mem_q[idx];
    shifted = word >> {off, 3'b000};
    case (req_funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  // Store lanes replicate the low data bytes so the byte enable alone picks the target bytes.
  always_comb begin
    case (sz)
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << off;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
    wr_en = accept && req_we && (code == FC_NONE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d = (req_we || (code != FC_NONE)) ? 32'd0 : load_val;
          fault_d = (code != FC_NONE);
          code_d  = code;
          cnt_d   = 2'(RD_LAT - 1);
          state_d = (RD_LAT == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RST) begin
        for (int i = 0; i < WORDS; i++) mem_q[i] <= 32'd0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule
